// File: rtl/cordic_bus_pkg.sv
// Shared definitions for the CORDIC APB bridge: register word map and
// default control-bit positions.
package cordic_bus_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned START_BIT = 0;
  localparam int unsigned BUSY_BIT  = 1;
  localparam int unsigned DONE_BIT  = 2;

  typedef enum logic [2:0] {
    ADDR_X    = 3'd0,
    ADDR_Y    = 3'd1,
    ADDR_Z    = 3'd2,
    ADDR_CTRL = 3'd3,
    ADDR_XRES = 3'd4,
    ADDR_YRES = 3'd5,
    ADDR_ZRES = 3'd6,
    ADDR_IRQ  = 3'd7
  } addr_e;

endpackage

// File: rtl/BusInterface.sv
// Connection between the APB bridge (bus side) and the CORDIC controller.
interface BusInterface #(
  parameter int unsigned p_WIDTH = 32
) ();

  logic               clk;
  logic               rst;
  logic [p_WIDTH-1:0] xInput;
  logic [p_WIDTH-1:0] yInput;
  logic [p_WIDTH-1:0] zInput;
  logic [p_WIDTH-1:0] controlRegisterInput;
  logic [p_WIDTH-1:0] controlRegisterOutput;
  logic [p_WIDTH-1:0] controlRegisterMask;
  logic [p_WIDTH-1:0] xResult;
  logic [p_WIDTH-1:0] yResult;
  logic [p_WIDTH-1:0] zResult;

  modport bus (
    output clk, rst, xInput, yInput, zInput, controlRegisterInput,
    input  controlRegisterOutput, controlRegisterMask, xResult, yResult, zResult
  );

  modport ctrl (
    input  clk, rst, xInput, yInput, zInput, controlRegisterInput,
    output controlRegisterOutput, controlRegisterMask, xResult, yResult, zResult
  );

endinterface

// File: rtl/cordic_apb_bridge.sv
// APB3 slave exposing CORDIC operands, control and snapshotted results,
// with controller-owned control bits merged in and a level completion IRQ.
module cordic_apb_bridge
  import cordic_bus_pkg::*;
#(
  parameter int unsigned p_WIDTH     = DATA_W,
  parameter int unsigned p_START_BIT = START_BIT,
  parameter int unsigned p_BUSY_BIT  = BUSY_BIT,
  parameter int unsigned p_DONE_BIT  = DONE_BIT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [4:0]         paddr,
  input  logic [p_WIDTH-1:0] pwdata,
  output logic [p_WIDTH-1:0] prdata,
  output logic               pready,
  output logic               pslverr,
  output logic               irq,
  BusInterface.bus           cordicBus
);

  logic [p_WIDTH-1:0] x_q, y_q, z_q, ctrl_q;
  logic [p_WIDTH-1:0] xres_q, yres_q, zres_q;
  logic [p_WIDTH-1:0] ctrl_base, ctrl_d;
  logic               done_prev, irq_q, irq_d;
  logic               access, wr, wr_ok, reject;
  logic               is_operand, is_ro, done_edge;
  addr_e              word;
  logic [1:0]         unused_addr_lsb;

  assign unused_addr_lsb = paddr[1:0];
  assign word            = addr_e'(paddr[4:2]);

  // Access decode; operand/control writes bounce while the controller is busy.
  assign access     = psel & penable;
  assign wr         = access & pwrite;
  assign is_operand = (word == ADDR_X) | (word == ADDR_Y) |
                      (word == ADDR_Z) | (word == ADDR_CTRL);
  assign is_ro      = (word == ADDR_XRES) | (word == ADDR_YRES) | (word == ADDR_ZRES);
  assign reject     = wr & (is_ro | (is_operand & ctrl_q[p_BUSY_BIT]));
  assign wr_ok      = wr & ~reject;
  assign done_edge  = ctrl_q[p_DONE_BIT] & ~done_prev;

  // START lasts one cycle: a set bit always clears on the following edge.
  always_comb begin
    ctrl_base = ctrl_q;
    if (wr_ok && (word == ADDR_CTRL)) ctrl_base = pwdata;
    ctrl_base[p_START_BIT] = ctrl_base[p_START_BIT] & ~ctrl_q[p_START_BIT];
    ctrl_d = (ctrl_base & ~cordicBus.controlRegisterMask) |
             (cordicBus.controlRegisterOutput & cordicBus.controlRegisterMask);
  end

  // A completion outranks a simultaneous write-1-to-clear.
  always_comb begin
    irq_d = irq_q;
    if (done_edge) irq_d = 1'b1;
    else if (wr && (word == ADDR_IRQ) && pwdata[0]) irq_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      ctrl_q    <= '0;
      xres_q    <= '0;
      yres_q    <= '0;
      zres_q    <= '0;
      done_prev <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (wr_ok && (word == ADDR_X)) x_q <= pwdata;
      if (wr_ok && (word == ADDR_Y)) y_q <= pwdata;
      if (wr_ok && (word == ADDR_Z)) z_q <= pwdata;
      ctrl_q    <= ctrl_d;
      done_prev <= ctrl_q[p_DONE_BIT];
      if (done_edge) begin
        xres_q <= cordicBus.xResult;
        yres_q <= cordicBus.yResult;
        zres_q <= cordicBus.zResult;
      end
      irq_q <= irq_d;
    end
  end

  always_comb begin
    prdata = '0;
    if (access) begin
      case (word)
        ADDR_X:    prdata = x_q;
        ADDR_Y:    prdata = y_q;
        ADDR_Z:    prdata = z_q;
        ADDR_CTRL: prdata = ctrl_q;
        ADDR_XRES: prdata = xres_q;
        ADDR_YRES: prdata = yres_q;
        ADDR_ZRES: prdata = zres_q;
        ADDR_IRQ:  prdata = p_WIDTH'(irq_q);
        default:   prdata = '0;
      endcase
    end
  end

  assign pready  = 1'b1;
  assign pslverr = reject;
  assign irq     = irq_q;

  assign cordicBus.clk                  = clk;
  assign cordicBus.rst                  = rst;
  assign cordicBus.xInput               = x_q;
  assign cordicBus.yInput               = y_q;
  assign cordicBus.zInput               = z_q;
  assign cordicBus.controlRegisterInput = ctrl_q;

endmodule

// File: tb/tb_cordic_apb_bridge.sv
// Self-checking bench for cordic_apb_bridge against a register-level model.
module tb_cordic_apb_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [4:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr, irq;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_reg [8];
  logic        m_irq;

  BusInterface #(.p_WIDTH(32)) cbus ();

  cordic_apb_bridge dut (
    .clk       (clk),
    .rst       (rst),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .irq       (irq),
    .cordicBus (cbus)
  );

  always #5 clk = ~clk;

  // Full APB write; returns 1 time unit after the committing edge.
  task automatic apb_write(input int word, input logic [31:0] data, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; pwdata = data;
    paddr = 5'((word << 2) | int'($urandom_range(0, 3)));
    @(posedge clk); #1 penable = 1'b1;
    #1 err = pslverr;
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input int word, output logic [31:0] data);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
    paddr = 5'((word << 2) | int'($urandom_range(0, 3)));
    @(posedge clk); #1 penable = 1'b1;
    #1 data = prdata;
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
  endtask

  // Expected outcome of a CPU write, from the register map rules.
  task automatic model_write(input int word, input logic [31:0] data, output logic exp_err);
    exp_err = 1'b0;
    if (word >= 4 && word <= 6) exp_err = 1'b1;
    else if (word <= 3 && m_reg[3][1]) exp_err = 1'b1;
    else if (word <= 2) m_reg[word] = data;
    else if (word == 3) m_reg[3] = data & ~32'h1;
    else if (word == 7 && data[0]) m_irq = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      psel = 1'b1; penable = 1'b0; pwrite = 1'($urandom);
      paddr = 5'($urandom); pwdata = $urandom;
      @(posedge clk); #1 penable = 1'b1;
      #1;
      checks++;
      if (!pwrite && prdata !== 32'h0) begin
        errors++; $display("FAIL reset_read: got %h want 0", prdata);
      end
      checks++;
      if (irq !== 1'b0 || cbus.controlRegisterInput !== 32'h0) begin
        errors++; $display("FAIL reset_outputs: irq %b cri %h want 0", irq, cbus.controlRegisterInput);
      end
      @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    end
    rst = 1'b1;
    for (int w = 0; w < 8; w++) m_reg[w] = '0;
    m_irq = 1'b0;
    for (int w = 0; w < 8; w++) begin
      logic [31:0] rd;
      apb_read(w, rd);
      checks++;
      if (rd !== 32'h0) begin
        errors++; $display("FAIL post_reset_word%0d: got %h want 0", w, rd);
      end
    end
    checks++;
    if (pready !== 1'b1) begin
      errors++; $display("FAIL pready: got %b want 1", pready);
    end
  endtask

  task automatic test_operand_start();
    logic err;
    logic [31:0] rd;
    apb_write(0, 32'h0000_1000, err); model_write(0, 32'h0000_1000, err);
    apb_write(1, 32'h0, err);         model_write(1, 32'h0, err);
    apb_write(2, 32'h2000_0000, err); model_write(2, 32'h2000_0000, err);
    checks++;
    if (cbus.xInput !== 32'h1000 || cbus.yInput !== 32'h0 || cbus.zInput !== 32'h2000_0000) begin
      errors++; $display("FAIL operand_bus: got %h %h %h want 1000 0 20000000",
                         cbus.xInput, cbus.yInput, cbus.zInput);
    end
    apb_write(3, 32'h1, err); model_write(3, 32'h1, err);
    checks++;
    if (cbus.controlRegisterInput[0] !== 1'b1) begin
      errors++; $display("FAIL start_high: got %b want 1", cbus.controlRegisterInput[0]);
    end
    @(posedge clk); #1;
    checks++;
    if (cbus.controlRegisterInput[0] !== 1'b0) begin
      errors++; $display("FAIL start_clear: got %b want 0", cbus.controlRegisterInput[0]);
    end
    apb_read(3, rd);
    checks++;
    if (rd !== m_reg[3]) begin
      errors++; $display("FAIL ctrl_readback: got %h want %h", rd, m_reg[3]);
    end
  endtask

  task automatic test_random_regs();
    for (int i = 0; i < 16; i++) begin
      int w, rw;
      logic [31:0] data, rd;
      logic err, exp_err;
      w = int'($urandom_range(0, 7));
      data = $urandom;
      if (w == 3) data = data & ~32'h7;
      apb_write(w, data, err);
      model_write(w, data, exp_err);
      checks++;
      if (err !== exp_err) begin
        errors++; $display("FAIL rand_pslverr word%0d: got %b want %b", w, err, exp_err);
      end
      rw = int'($urandom_range(0, 7));
      apb_read(rw, rd);
      checks++;
      if (rd !== ((rw == 7) ? 32'(m_irq) : m_reg[rw])) begin
        errors++; $display("FAIL rand_read word%0d: got %h want %h", rw, rd,
                           (rw == 7) ? 32'(m_irq) : m_reg[rw]);
      end
    end
    checks++;
    if (cbus.xInput !== m_reg[0] || cbus.yInput !== m_reg[1] ||
        cbus.zInput !== m_reg[2] || cbus.controlRegisterInput !== m_reg[3]) begin
      errors++; $display("FAIL rand_bus: got %h %h %h %h", cbus.xInput, cbus.yInput,
                         cbus.zInput, cbus.controlRegisterInput);
    end
  endtask

  task automatic test_mask_merge();
    logic err;
    logic [31:0] rd;
    apb_write(3, 32'h0, err); model_write(3, 32'h0, err);
    cbus.controlRegisterMask   = 32'h6;
    cbus.controlRegisterOutput = 32'h2;
    m_reg[3] = 32'h2;
    repeat (2) @(posedge clk);
    #1;
    apb_read(3, rd);
    checks++;
    if (rd !== 32'h2) begin
      errors++; $display("FAIL merge_readback: got %h want 2", rd);
    end
    apb_write(3, 32'h6, err);
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL busy_ctrl_pslverr: got %b want 1", err);
    end
    apb_read(3, rd);
    checks++;
    if (rd !== 32'h2) begin
      errors++; $display("FAIL busy_ctrl_readback: got %h want 2", rd);
    end
    apb_write(0, 32'h55, err);
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL busy_x_pslverr: got %b want 1", err);
    end
    apb_read(0, rd);
    checks++;
    if (rd !== m_reg[0] || cbus.xInput !== m_reg[0]) begin
      errors++; $display("FAIL busy_x_kept: got %h want %h", rd, m_reg[0]);
    end
    cbus.controlRegisterOutput = 32'h0;
    m_reg[3] = 32'h0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_completion();
    logic [31:0] rd;
    cbus.xResult = 32'h0000_DEAD;
    cbus.yResult = $urandom;
    cbus.zResult = $urandom;
    m_reg[4] = 32'h0000_DEAD; m_reg[5] = cbus.yResult; m_reg[6] = cbus.zResult;
    cbus.controlRegisterOutput = 32'h4;
    @(posedge clk); #1;
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_early: got %b want 0", irq);
    end
    @(posedge clk); #1;
    m_irq = 1'b1;
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL irq_set: got %b want 1", irq);
    end
    cbus.xResult = $urandom;
    for (int w = 4; w < 7; w++) begin
      apb_read(w, rd);
      checks++;
      if (rd !== m_reg[w]) begin
        errors++; $display("FAIL result_word%0d: got %h want %h", w, rd, m_reg[w]);
      end
    end
    cbus.controlRegisterOutput = 32'h0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_irq_race();
    logic err;
    logic [31:0] rd, v2;
    v2 = $urandom;
    cbus.xResult = v2;
    cbus.controlRegisterOutput = 32'h4;
    apb_write(7, 32'h1, err);
    m_reg[4] = v2;
    checks++;
    if (irq !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL irq_race: got irq %b err %b want 1 0", irq, err);
    end
    apb_read(4, rd);
    checks++;
    if (rd !== v2) begin
      errors++; $display("FAIL race_capture: got %h want %h", rd, v2);
    end
    apb_write(7, 32'h1, err);
    m_irq = 1'b0;
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_w1c: got %b want 0", irq);
    end
    cbus.controlRegisterOutput = 32'h0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_ro_error();
    logic err;
    logic [31:0] rd;
    for (int w = 4; w < 7; w++) begin
      apb_write(w, 32'hFFFF, err);
      checks++;
      if (err !== 1'b1) begin
        errors++; $display("FAIL ro_pslverr word%0d: got %b want 1", w, err);
      end
      apb_read(w, rd);
      checks++;
      if (rd !== m_reg[w]) begin
        errors++; $display("FAIL ro_kept word%0d: got %h want %h", w, rd, m_reg[w]);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic err;
    logic [31:0] rd;
    cbus.controlRegisterOutput = 32'h4;
    repeat (3) @(posedge clk);
    #1 cbus.controlRegisterOutput = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL pre_reset_irq: got %b want 1", irq);
    end
    apb_write(3, 32'h1, err);
    cbus.controlRegisterOutput = 32'h2;
    #1 rst = 1'b0;
    #1;
    checks++;
    if (irq !== 1'b0 || cbus.controlRegisterInput !== 32'h0 || cbus.rst !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got irq %b cri %h rst %b want 0 0 0",
                         irq, cbus.controlRegisterInput, cbus.rst);
    end
    @(posedge clk); #1 rst = 1'b1;
    cbus.controlRegisterOutput = 32'h0;
    apb_read(4, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL reset_snapshot: got %h want 0", rd);
    end
    apb_read(7, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL reset_irqreg: got %h want 0", rd);
    end
  endtask

  initial begin
    cbus.controlRegisterOutput = '0;
    cbus.controlRegisterMask   = '0;
    cbus.xResult = '0;
    cbus.yResult = '0;
    cbus.zResult = '0;
    test_reset();
    test_operand_start();
    test_random_regs();
    test_mask_merge();
    test_completion();
    test_irq_race();
    test_ro_error();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
